// File: rtl/step_sequencer.sv
// step_sequencer: step counter, instruction register, run/halt FSM and retired counter for the multicycle controller.
// Optional macro SEQ_WATCHDOG_EN halts with Seq_Err when an instruction overruns step 7.
module step_sequencer #(
  parameter int FETCH_STEP = 1,
  parameter int RET_W      = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic [15:0]      MemData,
  input  logic             Buff_PC,
  output logic [2:0]       Cnt,
  output logic [15:0]      IR,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic             Busy,
  output logic             Halt,
  output logic             Seq_Err,
  output logic [RET_W-1:0] Retired
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [2:0] FS = 3'(FETCH_STEP);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic err_q, err_d, busy_q, busy_d, halt_q, halt_d;
  logic run_st, done, is_hlt;
  always_comb begin
    run_st = state_q == RUN;
    done   = run_st && Buff_PC && cnt_q > FS;
    is_hlt = ir_q[15:11] == 5'b11100 && ir_q[1:0] == 2'b01;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ir_d    = run_st && cnt_q == FS ? MemData : ir_q;
    ret_d   = done ? ret_q + RET_W'(1) : ret_q;
    if (state_q == IDLE) begin
      cnt_d   = 3'd0;
      state_d = Run ? RUN : IDLE;
    end else if (run_st) begin
      if (done) begin
        cnt_d   = 3'd0;
        state_d = is_hlt ? HALT : RUN;
      end else if (cnt_q == 3'd7) begin
`ifdef SEQ_WATCHDOG_EN
        err_d   = 1'b1;
        state_d = HALT;
`endif
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      cnt_d = 3'd0;
    end
    busy_d = state_d == RUN;
    halt_d = state_d == HALT;
  end
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ir_q    <= 16'h0000;
      ret_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
    end
  end
  assign Cnt     = cnt_q;
  assign IR      = ir_q;
  assign InsM    = ir_q[15:11];
  assign InsL    = ir_q[1:0];
  assign Busy    = busy_q;
  assign Halt    = halt_q;
  assign Seq_Err = err_q;
  assign Retired = ret_q;
endmodule

// File: doc/step_sequencer.md
# step_sequencer

Step sequencer and instruction register for the multicycle RISC controller. It generates the 3-bit step counter `Cnt` and holds the fetched instruction. It drives the `Cnt`, `InsM[15:11]` and `InsL[1:0]` inputs of the per-signal decoders (`Signal_Buff_PC`, `Signal_Buff_PSW`, …). It consumes `Buff_PC` as the end-of-instruction indication, which restarts the step count. It also owns the run/halt state and a retired-instruction counter.

## Interface
- `FETCH_STEP`, default 1: step value of `Cnt` at which `IR` loads from `MemData`.
- `RET_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `Run`  in  1  start request; sampled only in IDLE.
- `MemData`  in  16  instruction word from memory; valid when `Cnt == FETCH_STEP`.
- `Buff_PC`  in  1  end-of-instruction from `Signal_Buff_PC`.
- `Cnt`  out  3  current step.
- `IR`  out  16  instruction register.
- `InsM`  out  5  `IR[15:11]`.
- `InsL`  out  2  `IR[1:0]`.
- `Busy`  out  1  high in RUN.
- `Halt`  out  1  high in HALT.
- `Seq_Err`  out  1  sticky step-overrun error.
- `Retired`  out  RET_W  count of completed instructions.

## Operation
- States: IDLE, RUN, HALT.
- Reset (asynchronous, `Rst = 1`) forces:
  - state IDLE
  - `Cnt = 0`, `IR = 16'h0000`
  - `Busy = 0`, `Halt = 0`, `Seq_Err = 0`, `Retired = 0`
- IDLE:
  - `Cnt` holds 0.
  - `Run = 1` → RUN on the next edge; `Cnt` stays 0 on that edge.
- RUN, evaluated each edge in this priority:
  1. Completion: `Buff_PC = 1` and `Cnt > FETCH_STEP`.
     - `Cnt` ← 0 and `Retired` ← `Retired + 1`; `Retired` wraps to 0 on overflow.
     - If `IR` decodes HLT (`InsM = 5'b11100`, `InsL = 2'b01`), go to HALT.
     - Otherwise stay in RUN.
  2. Overrun: `Cnt = 7` (watchdog; see Configuration).
  3. Otherwise `Cnt` ← `Cnt + 1`.
  - If `Buff_PC = 1` with `Cnt ≤ FETCH_STEP`, it is ignored and `Cnt` increments normally.
- IR load:
  - On any RUN edge with `Cnt == FETCH_STEP`, `IR` ← `MemData`.
  - `IR` is never loaded in IDLE or HALT.
- HALT:
  - `Cnt` holds 0; `IR`, `Retired` and `Seq_Err` hold.
  - `Run` is ignored; only `Rst` exits HALT.
- `Run` is ignored in RUN and HALT.
- `InsM` and `InsL` are pure slices of `IR`; there is no extra register stage.

## Timing
- All outputs are registered, or slices of registers, and change only on a `clk` rising edge, except on `Rst` assertion.
- Start latency: `Run` sampled at edge N → `Busy = 1` after N; `Cnt = 1` after N+1.
- Fetch: with `FETCH_STEP = 1`, `IR` is valid after the edge that leaves `Cnt = 1`, i.e. from `Cnt = 2` onward. Decoders see the previous instruction at `Cnt = 0` and `Cnt = 1`.
- Completion: `Buff_PC` high at step k, where `FETCH_STEP < k ≤ 7` → `Cnt = 0` after the next edge. An instruction of length k occupies k+1 cycles.
- HLT: `Busy` falls and `Halt` rises on the same edge that clears `Cnt`.
- `Buff_PC` at `Cnt = 7` is a normal completion; it takes priority over the overrun check.
- `Rst` asserted mid-instruction aborts immediately and asynchronously; the partial instruction is not counted in `Retired`.

## Configuration
- Macro: `SEQ_WATCHDOG_EN`.
- Defined:
  - RUN with `Cnt = 7` and `Buff_PC = 0` sets `Seq_Err = 1`, enters HALT and clears `Cnt` to 0.
  - `Seq_Err` stays set until `Rst`.
- Not defined:
  - `Cnt` wraps 7 → 0 and the sequencer stays in RUN.
  - No `IR` reload happens until `Cnt` reaches `FETCH_STEP` again.
  - `Seq_Err` is tied to 0.

## Test plan
- Reset/idle: assert `Rst` during RUN at `Cnt = 3` → next sample shows `Cnt = 0`, `IR = 0`, `Busy = 0`, `Retired = 0`. Hold `Run = 0` for 10 cycles → `Cnt` stays 0.
- Normal instruction: pulse `Run`, `MemData = 16'h0E01` at `Cnt = 1`, `Buff_PC` at `Cnt = 4`.
  - `Cnt` sequence is 0,1,2,3,4,0.
  - `InsM = 5'b00001` from `Cnt = 2`.
  - `Retired = 1`.
- Early `Buff_PC`: assert at `Cnt = 1` → ignored; `Cnt` goes to 2 and `IR` loads.
- HLT: load `16'hE001`, `Buff_PC` at `Cnt = 3`.
  - Result: `Halt = 1`, `Busy = 0`, `Cnt = 0`, `Retired` incremented.
  - A subsequent `Run` pulse has no effect.
- Overrun with `SEQ_WATCHDOG_EN` defined: never assert `Buff_PC` → after `Cnt = 7`, `Seq_Err = 1`, `Halt = 1`, `Cnt = 0`.
- Overrun without the macro: never assert `Buff_PC` → `Cnt` wraps 7 → 0 → 1, `IR` reloads at `Cnt = 1`, `Seq_Err = 0`.
